// File: rtl/tt04_poc_usbdev.sv
// USB full-speed device line engine: 4x-oversampled receiver (sync, NRZI,
// destuff, SYNC/EOP framing) plus a fixed ACK handshake transmitter.
module tt04_poc_usbdev #(
  parameter int OSR         = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int            PW      = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(OSR - 1);
  localparam logic [PW-1:0] PH_MID  = PW'(OSR / 2);
  // Line states are {D-, D+}.
  localparam logic [1:0]    LS_J    = 2'b01;
  localparam logic [1:0]    LS_K    = 2'b10;
  // SYNC (00000001) then ACK PID 0xD2, both in transmission order from bit 0.
  localparam logic [15:0]   TX_BITS = 16'hD280;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_SYNC,
    RX_DATA,
    RX_EOP,
    RX_WAIT_J
  } rx_state_t;

  logic unused_inputs;
  assign unused_inputs = &{1'b0, ui_in[7:3], uio_in[7:2]};

  // ---------------- input synchroniser ----------------
  logic [1:0] sync_q [SYNC_STAGES];

  // NOTE: the synchroniser chain is reset to J so the line does not look
  // like SE0 for the first few cycles after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= LS_J;
    end else begin
      sync_q[0] <= uio_in[1:0];
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  logic [1:0] line;
  logic       is_se0, is_j, is_k;
  assign line   = sync_q[SYNC_STAGES-1];
  assign is_j   = (line == LS_J);
  assign is_k   = (line == LS_K);
  assign is_se0 = !is_j && !is_k;

  // ---------------- DPLL ----------------
  logic [1:0]    line_d, prev_samp;
  logic [PW-1:0] phase_q, phase_n;
  logic          sample, nrzi_bit;

  always_comb begin
    if (line != line_d)        phase_n = '0;
    else if (phase_q == PH_LAST) phase_n = '0;
    else                       phase_n = phase_q + 1'b1;
  end

  assign sample   = (phase_n == PH_MID);
  assign nrzi_bit = (line == prev_samp);

  // NOTE: every clocked register uses non-blocking assignment so all state
  // updates see the values from before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_d    <= LS_J;
      phase_q   <= '0;
      prev_samp <= LS_J;
    end else begin
      line_d  <= line;
      phase_q <= phase_n;
      if (sample) prev_samp <= line;
    end
  end

  // ---------------- receive FSM ----------------
  rx_state_t  state_q, state_n;
  logic [2:0] sync_cnt_q, sync_cnt_n;
  logic [2:0] bit_cnt_q, bit_cnt_n;
  logic [2:0] ones_q, ones_n;
  logic [7:0] shreg_q, shreg_n;
  logic [7:0] data_q, data_n;
  logic       byte_tgl_q, byte_tgl_n;
  logic       first_q, first_n;
  logic       eop2_q, eop2_n;
  logic       rx_active_q, rx_active_n;
  logic       pkt_done_q, pkt_done_n;
  logic       pid_err_q, pid_err_n;
  logic       frame_err_q, frame_err_n;
  logic       tx_busy_q;

  // NOTE: every next-state variable takes its current value first, so no
  // path through this block can leave one unassigned and infer a latch.
  always_comb begin
    state_n     = state_q;
    sync_cnt_n  = sync_cnt_q;
    bit_cnt_n   = bit_cnt_q;
    ones_n      = ones_q;
    shreg_n     = shreg_q;
    data_n      = data_q;
    byte_tgl_n  = byte_tgl_q;
    first_n     = first_q;
    eop2_n      = eop2_q;
    rx_active_n = rx_active_q;
    pkt_done_n  = pkt_done_q;
    pid_err_n   = pid_err_q;
    frame_err_n = frame_err_q;

    if (tx_busy_q) begin
      state_n = RX_IDLE;
    end else if (sample) begin
      unique case (state_q)
        RX_IDLE: begin
          if (is_k) begin
            state_n    = RX_SYNC;
            sync_cnt_n = 3'd1;
          end
        end
        RX_SYNC: begin
          if (is_se0) begin
            state_n = RX_WAIT_J;
          end else if (sync_cnt_q != 3'd7) begin
            if (!nrzi_bit) sync_cnt_n = sync_cnt_q + 3'd1;
            else           state_n    = RX_WAIT_J;
          end else if (nrzi_bit) begin
            state_n     = RX_DATA;
            bit_cnt_n   = '0;
            ones_n      = '0;
            first_n     = 1'b1;
            rx_active_n = 1'b1;
            pkt_done_n  = 1'b0;
            pid_err_n   = 1'b0;
            frame_err_n = 1'b0;
          end else begin
            state_n = RX_WAIT_J;
          end
        end
        RX_DATA: begin
          if (is_se0) begin
            state_n = RX_EOP;
            eop2_n  = 1'b0;
            if (bit_cnt_q != 3'd0) frame_err_n = 1'b1;
          end else if (ones_q == 3'd6) begin
            // Six ones in a row: this bit is a stuff bit and must be 0.
            if (nrzi_bit) begin
              frame_err_n = 1'b1;
              state_n     = RX_WAIT_J;
            end else begin
              ones_n = '0;
            end
          end else begin
            shreg_n   = {nrzi_bit, shreg_q[7:1]};
            ones_n    = nrzi_bit ? ones_q + 3'd1 : 3'd0;
            bit_cnt_n = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              data_n     = shreg_n;
              byte_tgl_n = !byte_tgl_q;
              first_n    = 1'b0;
              if (first_q && (shreg_n[7:4] != ~shreg_n[3:0])) pid_err_n = 1'b1;
            end
          end
        end
        RX_EOP: begin
          if (is_se0) begin
            eop2_n = 1'b1;
          end else if (eop2_q && is_j) begin
            pkt_done_n  = 1'b1;
            rx_active_n = 1'b0;
            state_n     = RX_IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = RX_WAIT_J;
          end
        end
        RX_WAIT_J: begin
          if (is_j) state_n = RX_IDLE;
        end
        default: state_n = RX_IDLE;
      endcase
    end

    if (state_n == RX_WAIT_J) rx_active_n = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RX_IDLE;
      sync_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      ones_q      <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      byte_tgl_q  <= 1'b0;
      first_q     <= 1'b0;
      eop2_q      <= 1'b0;
      rx_active_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      pid_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      sync_cnt_q  <= sync_cnt_n;
      bit_cnt_q   <= bit_cnt_n;
      ones_q      <= ones_n;
      shreg_q     <= shreg_n;
      data_q      <= data_n;
      byte_tgl_q  <= byte_tgl_n;
      first_q     <= first_n;
      eop2_q      <= eop2_n;
      rx_active_q <= rx_active_n;
      pkt_done_q  <= pkt_done_n;
      pid_err_q   <= pid_err_n;
      frame_err_q <= frame_err_n;
    end
  end

  // ---------------- ACK transmitter ----------------
  logic          req_q, req_d, tx_start;
  logic [4:0]    tx_bit_q;
  logic [PW-1:0] tx_ph_q;
  logic          tx_lvl_q;   // 1 = J
  logic [3:0]    tx_nxt_idx;
  logic [1:0]    tx_line;

  assign tx_start   = req_q && !req_d && ena && (state_q == RX_IDLE) && !tx_busy_q;
  assign tx_nxt_idx = tx_bit_q[3:0] + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q     <= 1'b0;
      req_d     <= 1'b0;
      tx_busy_q <= 1'b0;
      tx_bit_q  <= '0;
      tx_ph_q   <= '0;
      tx_lvl_q  <= 1'b1;
    end else begin
      req_q <= ui_in[0];
      req_d <= req_q;
      if (tx_start) begin
        tx_busy_q <= 1'b1;
        tx_bit_q  <= '0;
        tx_ph_q   <= '0;
        tx_lvl_q  <= TX_BITS[0];   // encoder starts from J: a 0 toggles to K
      end else if (tx_busy_q) begin
        if (tx_ph_q == PH_LAST) begin
          tx_ph_q <= '0;
          if (tx_bit_q == 5'd18) begin
            tx_busy_q <= 1'b0;
          end else begin
            tx_bit_q <= tx_bit_q + 5'd1;
            if (tx_bit_q < 5'd15 && !TX_BITS[tx_nxt_idx]) tx_lvl_q <= !tx_lvl_q;
          end
        end else begin
          tx_ph_q <= tx_ph_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    tx_line = 2'b00;
    if (tx_busy_q) begin
      if (tx_bit_q < 5'd16)       tx_line = tx_lvl_q ? LS_J : LS_K;
      else if (tx_bit_q == 5'd18) tx_line = LS_J;
    end
  end

  // ---------------- pad outputs ----------------
  logic pu_q, oe_pu_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pu_q    <= 1'b0;
      oe_pu_q <= 1'b0;
      uo_out  <= '0;
    end else begin
      pu_q    <= ui_in[1];
      oe_pu_q <= 1'b1;
      uo_out  <= ui_in[2] ? {rx_active_q, pkt_done_q, pid_err_q, frame_err_q,
                             is_se0, is_j, tx_busy_q, byte_tgl_q}
                          : data_q;
    end
  end

  assign uio_out = {5'b0, pu_q, tx_line};
  assign uio_oe  = {5'b0, oe_pu_q, {2{tx_busy_q && ena}}};

endmodule

// File: tb/tb_tt04_poc_usbdev.sv
// Directed bench for tt04_poc_usbdev: packet vector table plus hand-written
// reset, corrupt-SYNC, ACK transmit and mid-packet reset sequences.
module tb_tt04_poc_usbdev;

  logic       clk = 1'b0;
  logic       rst, ena;
  logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;

  tt04_poc_usbdev #(.OSR(4), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] J   = 2'b01;   // {D-, D+}
  localparam logic [1:0] K   = 2'b10;
  localparam logic [1:0] SE0 = 2'b00;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // Line driver: every line state is held for 4 clocks, aligned to negedge.
  logic [1:0] lvl;
  int         ones;

  task automatic put_line(input logic [1:0] ls);
    uio_in[1:0] = ls;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    if (!b) lvl = (lvl == J) ? K : J;
    put_line(lvl);
  endtask

  task automatic send_sync();
    lvl = J;
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    send_bit(1'b1);
    ones = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      send_bit(b[i]);
      ones = b[i] ? ones + 1 : 0;
      if (ones == 6) begin
        send_bit(1'b0);
        ones = 0;
      end
    end
  endtask

  task automatic send_eop();
    put_line(SE0);
    put_line(SE0);
    put_line(J);
    lvl = J;
    repeat (4) put_line(J);
  endtask

  task automatic read_out(input logic sel, output logic [7:0] v);
    ui_in[2] = sel;
    repeat (3) @(negedge clk);
    v = uo_out;
  endtask

  typedef struct {
    logic [23:0] bytes;       // byte 0 (PID) in [7:0]
    int          nbytes;
    int          extra_ones;  // raw 1 bits appended with no stuffing
    logic [7:0]  exp_data;
    logic        exp_pd, exp_pe, exp_fe;
    int          exp_nb;      // complete bytes received
  } vec_t;

  vec_t       vecs[6];
  logic [1:0] tx_exp[19];
  logic [7:0] v8;
  logic       tgl;
  int         k, bad;

  initial begin
    vecs[0] = '{bytes:24'h10_00_2D, nbytes:3, extra_ones:0, exp_data:8'h10,
                exp_pd:1'b1, exp_pe:1'b0, exp_fe:1'b0, exp_nb:3};
    vecs[1] = '{bytes:24'h00_FF_2D, nbytes:2, extra_ones:0, exp_data:8'hFF,
                exp_pd:1'b1, exp_pe:1'b0, exp_fe:1'b0, exp_nb:2};
    vecs[2] = '{bytes:24'h00_00_2D, nbytes:1, extra_ones:7, exp_data:8'h2D,
                exp_pd:1'b0, exp_pe:1'b0, exp_fe:1'b1, exp_nb:1};
    vecs[3] = '{bytes:24'h10_00_2E, nbytes:3, extra_ones:0, exp_data:8'h10,
                exp_pd:1'b1, exp_pe:1'b1, exp_fe:1'b0, exp_nb:3};
    vecs[4] = '{bytes:24'h00_00_2D, nbytes:1, extra_ones:3, exp_data:8'h2D,
                exp_pd:1'b1, exp_pe:1'b0, exp_fe:1'b1, exp_nb:1};
    vecs[5] = '{bytes:24'h00_7E_2D, nbytes:2, extra_ones:0, exp_data:8'h7E,
                exp_pd:1'b1, exp_pe:1'b0, exp_fe:1'b0, exp_nb:2};
    tx_exp = '{K, J, K, J, K, J, K, K, J, J, K, J, J, K, K, K, SE0, SE0, J};

    // Reset with lines at J.
    rst    = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h01;
    lvl    = J;
    ones   = 0;
    tgl    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_uo_out", uo_out, 8'h00);
    check("rst_uio_oe", uio_oe, 8'h00);
    check("rst_uio_out", uio_out, 8'h00);
    rst = 1'b0;
    @(posedge clk) #1;
    check("post_rst_uio_oe", uio_oe, 8'h04);
    ui_in[1] = 1'b1;
    read_out(1'b1, v8);
    check("post_rst_status", v8, 8'h04);
    read_out(1'b0, v8);
    check("post_rst_data", v8, 8'h00);

    // Packet vectors.
    for (int v = 0; v < 6; v++) begin
      ui_in[2] = 1'b1;
      repeat (8) put_line(J);
      send_sync();
      send_byte(vecs[v].bytes[7:0]);
      check($sformatf("v%0d_rx_active", v), {7'b0, uo_out[7]}, 8'h01);
      for (int i = 1; i < vecs[v].nbytes; i++) send_byte(vecs[v].bytes[8*i +: 8]);
      for (int i = 0; i < vecs[v].extra_ones; i++) send_bit(1'b1);
      send_eop();
      tgl = tgl ^ vecs[v].exp_nb[0];
      read_out(1'b0, v8);
      check($sformatf("v%0d_data", v), v8, vecs[v].exp_data);
      read_out(1'b1, v8);
      check($sformatf("v%0d_status", v), v8,
            {1'b0, vecs[v].exp_pd, vecs[v].exp_pe, vecs[v].exp_fe, 1'b0, 1'b1, 1'b0, tgl});
    end

    // Corrupt SYNC: flags and data must stay as the last packet left them.
    foreach (tx_exp[i]) ;
    put_line(K); put_line(J); put_line(K); put_line(J);
    put_line(K); put_line(K); put_line(J); put_line(K);
    repeat (8) put_line(J);
    read_out(1'b0, v8);
    check("badsync_data", v8, 8'h7E);
    read_out(1'b1, v8);
    check("badsync_status", v8, {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, tgl});

    // ACK transmit with ena=1.
    @(negedge clk);
    ui_in[0] = 1'b1;
    @(posedge clk) #1;
    check("tx_oe_clk1", uio_oe, 8'h04);
    @(posedge clk) #1;
    check("tx_oe_clk2", uio_oe, 8'h07);
    ui_in[0] = 1'b0;
    check("tx_pullup", {7'b0, uio_out[2]}, 8'h01);
    k = 0;
    while (uio_oe[1:0] == 2'b11 && k < 200) begin
      if (k % 4 == 1 && k / 4 < 19)
        check($sformatf("tx_bit%0d", k / 4), {6'b0, uio_out[1:0]}, {6'b0, tx_exp[k / 4]});
      k++;
      @(posedge clk) #1;
    end
    check("tx_len", 8'(k), 8'd76);
    check("tx_idle_out", {6'b0, uio_out[1:0]}, 8'h00);

    // Request with ena=0 must produce no drive.
    ena = 1'b0;
    @(negedge clk);
    ui_in[0] = 1'b1;
    bad = 0;
    repeat (20) begin
      @(posedge clk) #1;
      if (uio_oe[1:0] != 2'b00 || uio_out[1:0] != 2'b00) bad++;
    end
    ui_in[0] = 1'b0;
    check("noena_drive", 8'(bad), 8'd0);
    ena = 1'b1;

    // Reset asserted mid-packet.
    ui_in[2] = 1'b1;
    repeat (4) put_line(J);
    send_sync();
    send_byte(8'h2D);
    rst = 1'b1;
    @(posedge clk) #1;
    check("midrst_uo_out", uo_out, 8'h00);
    check("midrst_uio_oe", uio_oe, 8'h00);
    check("midrst_uio_out", uio_out, 8'h00);
    uio_in[1:0] = J;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop so the run can never hang.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
